alu_seq: RTL

- Parametrised, multi-cycle successor to the CPU's 8-bit ALU.
- Adds variable-distance shifts (iterated one bit per cycle) and an unsigned shift-add multiply to the existing operations: add, subtract, shift-by-1 and pass.
- Uses a Start/Busy/Done handshake so the control unit can stall on long operations.
- Holds the Z/N/V/C flag registers internally, with the same write-enable semantics as the current flag bank.

---
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU with a Start/Busy/Done handshake and an internal Z/N/V/C flag bank.
// Variable shifts iterate one bit per cycle; MUL is a WIDTH-step shift-add.
module alu_seq #(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic             Flags_Write_Enable,
  input  logic [WIDTH-1:0] ALU_Input0,
  input  logic [WIDTH-1:0] ALU_Input1,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALU_OUTPUT,
  output logic             ZeroFlagOut,
  output logic             NegativeFlagOut,
  output logic             OverFlowFlagOut,
  output logic             CarryFlagOut
);

  localparam int CNT_W = SHAMT_W + 1;

  typedef enum logic {IDLE, EXEC} state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_SHLN = 3'b100,
    OP_SHRN = 3'b101,
    OP_MUL  = 3'b110,
    OP_PASS = 3'b111
  } op_t;

  state_t             state, state_next;
  op_t                op_in, op_r;
  logic               fwe_r;
  logic               shift_en, shift_en_in;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH:0]     mul_sum, add_s, sub_s;
  logic [CNT_W-1:0]   cnt, cnt_load;
  logic [SHAMT_W-1:0] shamt;
  logic               final_cyc;
  logic               shift_left, shift_c;
  logic [WIDTH-1:0]   shift_v;
  logic [WIDTH-1:0]   res;
  logic               res_c, res_v;

  assign op_in     = op_t'(Op);
  assign shamt     = ALU_Input1[SHAMT_W-1:0];
  assign final_cyc = (state == EXEC) && (cnt == CNT_W'(1));

  // Iteration count: shifts by zero still take one cycle and leave A untouched.
  always_comb begin
    cnt_load    = CNT_W'(1);
    shift_en_in = 1'b0;
    case (op_in)
      OP_MUL: cnt_load = CNT_W'(WIDTH);
      OP_SHL, OP_SHR: shift_en_in = 1'b1;
      OP_SHLN, OP_SHRN: begin
        if (shamt != '0) begin
          cnt_load    = {1'b0, shamt};
          shift_en_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    Busy       = (state == EXEC);
    case (state)
      IDLE:    if (Start) state_next = EXEC;
      EXEC:    if (final_cyc) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_left = (op_r == OP_SHL) || (op_r == OP_SHLN);
    shift_v    = a_r;
    shift_c    = 1'b0;
    if (shift_en) begin
      if (shift_left) begin
        shift_v = {a_r[WIDTH-2:0], 1'b0};
        shift_c = a_r[WIDTH-1];
      end else begin
        shift_v = {1'b0, a_r[WIDTH-1:1]};
        shift_c = a_r[0];
      end
    end

    // acc = {partial high, remaining multiplier}; add then shift right as one step.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_r} : '0);
    acc_next = {mul_sum, acc[WIDTH-1:1]};

    add_s = {1'b0, a_r} + {1'b0, b_r};
    sub_s = {1'b0, a_r} + {1'b0, ~b_r} + {{WIDTH{1'b0}}, 1'b1};

    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_r)
      OP_ADD: begin
        res   = add_s[WIDTH-1:0];
        res_c = add_s[WIDTH];
        res_v = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        res   = sub_s[WIDTH-1:0];
        res_c = sub_s[WIDTH];
        res_v = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sub_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SHL, OP_SHR, OP_SHLN, OP_SHRN: begin
        res   = shift_v;
        res_c = shift_c;
      end
      OP_MUL: begin
        res   = acc_next[WIDTH-1:0];
        res_c = |acc_next[2*WIDTH-1:WIDTH];
        res_v = |acc_next[2*WIDTH-1:WIDTH];
      end
      default: res = b_r;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Done            <= 1'b0;
      ALU_OUTPUT      <= '0;
      ZeroFlagOut     <= 1'b0;
      NegativeFlagOut <= 1'b0;
      OverFlowFlagOut <= 1'b0;
      CarryFlagOut    <= 1'b0;
      a_r             <= '0;
      b_r             <= '0;
      acc             <= '0;
      cnt             <= '0;
      op_r            <= OP_ADD;
      fwe_r           <= 1'b0;
      shift_en        <= 1'b0;
    end else begin
      Done <= 1'b0;
      if ((state == IDLE) && Start) begin
        a_r      <= ALU_Input0;
        b_r      <= ALU_Input1;
        acc      <= {{WIDTH{1'b0}}, ALU_Input1};
        op_r     <= op_in;
        fwe_r    <= Flags_Write_Enable;
        cnt      <= cnt_load;
        shift_en <= shift_en_in;
      end else if (state == EXEC) begin
        cnt <= cnt - CNT_W'(1);
        acc <= acc_next;
        if (shift_en) a_r <= shift_v;
        if (final_cyc) begin
          Done       <= 1'b1;
          ALU_OUTPUT <= res;
          if (fwe_r) begin
            ZeroFlagOut     <= (res == '0);
            NegativeFlagOut <= res[WIDTH-1];
            OverFlowFlagOut <= res_v;
            CarryFlagOut    <= res_c;
          end
        end
      end
    end
  end

endmodule
